// File: rtl/led_log_pkg.sv
// Shared types and default parameters for the LED change logger.
// The optional per-entry cycle timestamp is enabled with LED_LOG_TIMESTAMP_EN.
package led_log_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_STABLE_CYC = 4;
    localparam int TS_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/led_log_fifo.sv
// Log FIFO: power-of-two circular buffer with a registered read port,
// a count-based empty/full pair and a sticky overflow flag.
module led_log_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     rd_en,
    output logic [DW-1:0]            dout,
    output logic                     dout_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             do_pop, do_push, do_drop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        do_pop  = rd_en && !empty;
        // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
        do_push = push && (!full || do_pop);
        do_drop = push && full && !do_pop;

        wr_ptr_d     = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        dout_d       = do_pop  ? mem_q[rd_ptr_q] : dout_q;
        dout_valid_d = do_pop;
        overflow_d   = overflow_q || do_drop;

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/led_change_logger.sv
// Synchronizes an asynchronous LED bus, qualifies changes over STABLE_CYC samples
// and logs accepted values into led_log_fifo. Optional macro: LED_LOG_TIMESTAMP_EN.
module led_change_logger
    import led_log_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       led_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
`ifdef LED_LOG_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]        ts_out
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
`ifdef LED_LOG_TIMESTAMP_EN
    localparam int DW = WIDTH + TS_W;
`else
    localparam int DW = WIDTH;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] led_s_q, led_s_d;
    logic [WIDTH-1:0] last_val_q, last_val_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic             push;
    logic [DW-1:0]    fifo_din;
    logic [DW-1:0]    fifo_dout;

    always_comb begin
        sync1_d    = led_in;
        led_s_d    = sync1_q;
        state_d    = state_q;
        last_val_d = last_val_q;
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        push       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (led_s_q != last_val_q) begin
                    cand_d     = led_s_q;
                    stab_cnt_d = CNT_W'(1);
                    state_d    = ST_QUAL;
                end
            end
            ST_QUAL: begin
                // cand always differs from last_val, so the order of these tests is safe.
                if (led_s_q == last_val_q) begin
                    state_d = ST_IDLE;
                end else if (led_s_q != cand_q) begin
                    cand_d     = led_s_q;
                    stab_cnt_d = CNT_W'(1);
                end else if (stab_cnt_q >= CNT_W'(STABLE_CYC)) begin
                    state_d = ST_COMMIT;
                end else begin
                    stab_cnt_d = stab_cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                push       = 1'b1;
                last_val_d = cand_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= '0;
            led_s_q    <= '0;
            last_val_q <= '0;
            cand_q     <= '0;
            stab_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            led_s_q    <= led_s_d;
            last_val_q <= last_val_d;
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

`ifdef LED_LOG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb ts_d = ts_q + TS_W'(1);

    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_d;
    end

    assign fifo_din = {ts_q, cand_q};
    assign dout     = fifo_dout[WIDTH-1:0];
    assign ts_out   = fifo_dout[DW-1 -: TS_W];
`else
    assign fifo_din = cand_q;
    assign dout     = fifo_dout;
`endif

    led_log_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (fifo_din),
        .rd_en      (rd_en),
        .dout       (fifo_dout),
        .dout_valid (dout_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_led_change_logger.sv
// Directed self-checking bench for led_change_logger (WIDTH=8, DEPTH=4, STABLE_CYC=4).
// Timestamp checks run only when LED_LOG_TIMESTAMP_EN is defined.
module tb_led_change_logger;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int STABLE_CYC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] led_in;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic [2:0]       count;
    logic             overflow;
`ifdef LED_LOG_TIMESTAMP_EN
    logic [15:0]      ts_out;
    logic [15:0]      ts_rec [3];
    logic [15:0]      ts_diff;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_change_logger #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
`ifdef LED_LOG_TIMESTAMP_EN
        .ts_out     (ts_out),
`endif
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        led_in = '0;
        rd_en  = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(dout_valid), 1);
        check({tag, "_data"}, 32'(dout), 32'(exp));
    endtask

    initial begin
        // Reset state and first change latency.
        do_reset();
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_dout_valid", 32'(dout_valid), 0);

        led_in = 8'h01;
        step(7);
        check("lat_empty_before", 32'(empty), 1);
        step(1);
        check("lat_empty_after", 32'(empty), 0);
        check("lat_count", 32'(count), 1);
        pop("first_pop", 8'h01);
        check("first_pop_empty", 32'(empty), 1);
        step(1);
        check("strobe_drop", 32'(dout_valid), 0);
        check("dout_hold", 32'(dout), 32'h01);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("empty_rd_valid", 32'(dout_valid), 0);
        check("empty_rd_dout", 32'(dout), 32'h01);
        check("empty_rd_count", 32'(count), 0);

        // Glitch rejection and mid-qualification replacement.
        do_reset();
        led_in = 8'h81;
        step(2);
        led_in = 8'h00;
        step(15);
        check("glitch_count", 32'(count), 0);
        check("glitch_empty", 32'(empty), 1);
        led_in = 8'h03;
        step(3);
        led_in = 8'h80;
        step(20);
        check("replace_count", 32'(count), 1);
        pop("replace_pop", 8'h80);
        check("replace_after_count", 32'(count), 0);

        // Overflow with five distinct held values.
        do_reset();
        led_in = 8'h01; step(12);
        led_in = 8'h03; step(12);
        led_in = 8'h81; step(12);
        led_in = 8'h80; step(12);
        check("fill_full", 32'(full), 1);
        check("fill_overflow", 32'(overflow), 0);
        led_in = 8'h00; step(12);
        check("ovf_full", 32'(full), 1);
        check("ovf_count", 32'(count), 4);
        check("ovf_flag", 32'(overflow), 1);
        pop("ovf_pop0", 8'h01);
        pop("ovf_pop1", 8'h03);
        pop("ovf_pop2", 8'h81);
        pop("ovf_pop3", 8'h80);
        check("ovf_drained", 32'(empty), 1);
        check("ovf_sticky", 32'(overflow), 1);

        // Full FIFO with a pop on the commit cycle.
        do_reset();
        led_in = 8'h01; step(12);
        led_in = 8'h03; step(12);
        led_in = 8'h81; step(12);
        led_in = 8'h80; step(12);
        check("pp_count_pre", 32'(count), 4);
        led_in = 8'h00;
        step(7);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("pp_count", 32'(count), 4);
        check("pp_full", 32'(full), 1);
        check("pp_overflow", 32'(overflow), 0);
        check("pp_valid", 32'(dout_valid), 1);
        check("pp_dout", 32'(dout), 32'h01);
        pop("pp_pop1", 8'h03);
        pop("pp_pop2", 8'h81);
        pop("pp_pop3", 8'h80);
        pop("pp_pop4", 8'h00);
        check("pp_drained", 32'(empty), 1);

        // Reset during COMMIT drops the pending push.
        do_reset();
        led_in = 8'h01;
        step(7);
        rst    = 1'b1;
        led_in = 8'h00;
        step(1);
        rst = 1'b0;
        check("rst_commit_count", 32'(count), 0);
        step(15);
        check("rst_commit_later", 32'(count), 0);

        // Reset during QUAL discards the candidate; a later hold logs it.
        do_reset();
        led_in = 8'h03;
        step(4);
        rst    = 1'b1;
        led_in = 8'h00;
        step(1);
        rst = 1'b0;
        step(15);
        check("rst_qual_count", 32'(count), 0);
        led_in = 8'h03;
        step(12);
        check("rst_qual_relog", 32'(count), 1);
        pop("rst_qual_pop", 8'h03);

`ifdef LED_LOG_TIMESTAMP_EN
        // Changes 20 cycles apart, the first pair straddling the counter wrap.
        do_reset();
        step(65520);
        led_in = 8'h01; step(20);
        led_in = 8'h02; step(20);
        led_in = 8'h04; step(20);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            step(1);
            rd_en = 1'b0;
            ts_rec[i] = ts_out;
        end
        ts_diff = ts_rec[1] - ts_rec[0];
        check("ts_wrap_diff", 32'(ts_diff), 20);
        check("ts_wrapped", 32'(ts_rec[1] < ts_rec[0]), 1);
        ts_diff = ts_rec[2] - ts_rec[1];
        check("ts_diff", 32'(ts_diff), 20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
